tmds_lvds_serializer: RTL and testbench
=======================================

# tmds_lvds_serializer

Single-clock 10:1 TMDS serializer with differential output stage for the HDMI transmit path. It sits after the per-channel TMDS symbol mux. Once every 10 bit-clock cycles it accepts three 10-bit channel symbols, then shifts them out LSB-first on three differential data pairs. A fourth pair carries the fixed TMDS clock pattern, aligned to the data words.

## Interface
- `LVDS_MODE`, default `"ELVDS"`: output buffer style.
  - Legal values are `"ELVDS"` (emulated LVDS) and `"TLVDS"` (true LVDS).
  - Both have identical logical behaviour.
  - Any other value is a fatal elaboration error.
- `i_clk`, input, 1 bit: bit clock at 10× pixel rate. Single clock; all logic is on its rising edge.
- `i_rst_n`, input, 1 bit: reset. **Synchronous, active-low.**
- `i_chan_vec`, input, [2:0][9:0]: channel symbols. Bit 0 of each symbol is transmitted first.
- `o_load`, output, 1 bit: one-cycle strobe. `i_chan_vec` is sampled on the rising edge that ends the cycle in which `o_load`=1.
- `o_hdmi_clk_p` / `o_hdmi_clk_n`, output, 1 bit each: TMDS clock pair.
- `o_hdmi_chan_p` / `o_hdmi_chan_n`, output, [2:0] each: TMDS data pairs, one per channel.

## Operation
- **Phase counter** `phase`, 4 bits, counts 0..9.
  - Increments every cycle; after 9 it wraps to 0.
  - `o_load` = (`phase` == 9), registered so it is glitch-free.
- **Load:** on the edge where `phase` == 9:
  - Each of 3 data shift registers loads `i_chan_vec[ch]`.
  - The clock shift register loads 10'b0000011111, i.e. D0..D4 = 1 and D5..D9 = 0.
- **Shift:** on all other edges, each shift register shifts right by one, filling with 0.
- **Outputs:**
  - `_p` is a register fed from bit 0 of the respective shift register.
  - `_n` = ~`_p`, taken from the same register stage; no combinational path from inputs.
- **Input sampling:** `i_chan_vec` is ignored except at the load edge. Words go back-to-back with no idle bits between them.
- **Clock pair:** outputs 1 for 5 bit times, then 0 for 5 bit times, phase-locked to the data words.

## Timing
- **Reset** (`i_rst_n`=0 at a rising edge):
  - `phase`=0, all shift registers = 0, `o_load`=0.
  - All `_p` outputs = 0 and all `_n` outputs = 1.
  - These values hold for as long as reset is asserted.
- **First load after release:**
  - Let edge 0 be the first edge with `i_rst_n`=1; `phase` becomes 1 at edge 0.
  - `o_load` is high during the cycle in which `phase`=9, and the word is sampled at the edge ending that cycle.
  - Exactly 10 edges separate consecutive loads; the first load edge is the 9th edge after edge 0.
- **Serial latency:**
  - D0 of a sampled word appears on `_p` one cycle after the load edge.
  - D1..D9 follow on the next 9 cycles.
  - D0 of the next word follows D9 immediately.
- **Reset mid-word:**
  - The word in flight is discarded and outputs return to reset values at the next edge.
  - Alignment restarts from `phase`=0; no partial word is emitted after release.
- **Pair alignment:** all four pairs change on the same edge, with zero cycle skew between clock and data pairs.
- **Complement rule:** `_n` is the exact complement of `_p` in every cycle, including during reset.

## Test plan
- **Reset values:** hold `i_rst_n`=0 for 5 cycles.
  - Expect `o_load`=0, all `_p`=0, all `_n`=1 throughout.
- **Load cadence:** release reset and run 50 cycles.
  - `o_load` pulses exactly once per 10 cycles, first in the 10th cycle after release, and each pulse is 1 cycle wide.
- **Bit order:** present ch0=10'b1101010100, ch1=10'h3FF, ch2=10'h000 at a load.
  - Starting the cycle after the load edge, `o_hdmi_chan_p[0]` = 0,0,1,0,1,0,1,0,1,1; ch1 stays 1; ch2 stays 0.
- **Clock pair:** over any 10-cycle word window, `o_hdmi_clk_p` = 1,1,1,1,1,0,0,0,0,0, aligned with the data D0..D9.
  - Check `_n` = ~`_p` every cycle on all four pairs.
- **Back-to-back / don't-care:**
  - Present 10'h155 then 10'h2AA on consecutive loads, toggling `i_chan_vec` randomly between loads.
  - The serial stream is exactly 1,0,1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,1,0,1.
- **Mid-word reset:**
  - Assert `i_rst_n`=0 for 1 cycle at bit 4 of a word; outputs return to reset values at the next edge.
  - The next `o_load` is in the 10th cycle after release, and the next word is emitted intact. Repeat with `LVDS_MODE`=`"TLVDS"` and expect identical waveforms.

Source files
------------

// File: rtl/tmds_lvds_serializer.sv
// 10:1 TMDS serializer for three data channels plus the TMDS clock pair.
// One word per channel is loaded every 10 bit-clock cycles and shifted out LSB first.
module tmds_lvds_serializer #(
  parameter string LVDS_MODE = "ELVDS"
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [2:0][9:0] i_chan_vec,
  output logic            o_load,
  output logic            o_hdmi_clk_p,
  output logic            o_hdmi_clk_n,
  output logic [2:0]      o_hdmi_chan_p,
  output logic [2:0]      o_hdmi_chan_n
);

  localparam logic [9:0] CLK_PATTERN = 10'b0000011111;

  logic [3:0]      phase;
  logic            load_edge;
  logic [2:0][9:0] chan_sr;
  logic [9:0]      clk_sr;
  logic            clk_q;
  logic [2:0]      chan_q;

  assign load_edge = (phase == 4'd9);

  // o_load is raised one cycle early so it is a clean register output during phase 9
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase  <= 4'd0;
      o_load <= 1'b0;
    end else begin
      phase  <= load_edge ? 4'd0 : phase + 4'd1;
      o_load <= (phase == 4'd8);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      chan_sr <= '0;
      clk_sr  <= '0;
    end else if (load_edge) begin
      chan_sr <= i_chan_vec;
      clk_sr  <= CLK_PATTERN;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        chan_sr[ch] <= {1'b0, chan_sr[ch][9:1]};
      end
      clk_sr <= {1'b0, clk_sr[9:1]};
    end
  end

  // Output stage: one register per pair, so all four pairs move on the same edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_q  <= 1'b0;
      chan_q <= '0;
    end else begin
      clk_q <= clk_sr[0];
      for (int ch = 0; ch < 3; ch++) begin
        chan_q[ch] <= chan_sr[ch][0];
      end
    end
  end

  // Both buffer styles are logically identical; only the mode name is validated
  if (LVDS_MODE != "ELVDS" && LVDS_MODE != "TLVDS") begin : g_bad_mode
    $fatal(1, "tmds_lvds_serializer: illegal LVDS_MODE %s", LVDS_MODE);
  end

  assign o_hdmi_clk_p  = clk_q;
  assign o_hdmi_clk_n  = ~clk_q;
  assign o_hdmi_chan_p = chan_q;
  assign o_hdmi_chan_n = ~chan_q;

endmodule

// File: tb/tb_tmds_lvds_serializer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle pair values, a monitor pops and checks.
// A TLVDS instance runs in parallel and must match the ELVDS instance every cycle.
module tb_tmds_lvds_serializer;

  typedef struct packed {
    logic       load;
    logic       clk;
    logic [2:0] chan;
  } exp_t;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [2:0][9:0] i_chan_vec = '0;

  logic       a_load, a_clk_p, a_clk_n;
  logic [2:0] a_chan_p, a_chan_n;
  logic       b_load, b_clk_p, b_clk_n;
  logic [2:0] b_chan_p, b_chan_n;

  int total = 0;
  int bad = 0;

  exp_t            exp_q[$];
  logic [29:0]     plan_q[$];
  int              next_edge = 0;
  bit              in_reset = 1'b1;

  tmds_lvds_serializer #(.LVDS_MODE("ELVDS")) dut_e (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_chan_vec(i_chan_vec),
    .o_load(a_load), .o_hdmi_clk_p(a_clk_p), .o_hdmi_clk_n(a_clk_n),
    .o_hdmi_chan_p(a_chan_p), .o_hdmi_chan_n(a_chan_n)
  );

  tmds_lvds_serializer #(.LVDS_MODE("TLVDS")) dut_t (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_chan_vec(i_chan_vec),
    .o_load(b_load), .o_hdmi_clk_p(b_clk_p), .o_hdmi_clk_n(b_clk_n),
    .o_hdmi_chan_p(b_chan_p), .o_hdmi_chan_n(b_chan_n)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: the transmitted stream is predicted from the words and load times alone
  task automatic applyStimulus(input bit rst_asserted);
    logic [2:0][9:0] w;
    exp_t e;
    @(negedge i_clk);
    if (rst_asserted) begin
      i_rst_n    = 1'b0;
      in_reset   = 1'b1;
      i_chan_vec = 30'($urandom);
    end else begin
      if (in_reset) begin
        exp_q.delete();
        for (int j = 0; j < 10; j++) begin
          e.load = (j == 8);
          e.clk  = 1'b0;
          e.chan = 3'b000;
          exp_q.push_back(e);
        end
        next_edge = 0;
        in_reset  = 1'b0;
      end
      i_rst_n = 1'b1;
      if (next_edge % 10 == 9) begin
        if (plan_q.size() > 0) w = plan_q.pop_front();
        else                   w = 30'($urandom);
        i_chan_vec = w;
        for (int j = 0; j < 10; j++) begin
          e.load = (j == 8);
          e.clk  = (j < 5);
          for (int ch = 0; ch < 3; ch++) e.chan[ch] = w[ch][j];
          exp_q.push_back(e);
        end
      end else begin
        i_chan_vec = 30'($urandom);
      end
      next_edge++;
    end
  endtask

  // Monitor: checks the outputs produced by each rising edge
  always @(posedge i_clk) begin
    exp_t e;
    #1;
    checkOutput("clk_complement", {31'd0, a_clk_n}, {31'd0, ~a_clk_p});
    checkOutput("chan_complement", {29'd0, a_chan_n}, {29'd0, ~a_chan_p});
    checkOutput("tlvds_match", {23'd0, b_load, b_clk_p, b_clk_n, b_chan_p, b_chan_n},
                {23'd0, a_load, a_clk_p, a_clk_n, a_chan_p, a_chan_n});
    if (!i_rst_n) begin
      checkOutput("rst_load", {31'd0, a_load}, 32'd0);
      checkOutput("rst_clk_p", {31'd0, a_clk_p}, 32'd0);
      checkOutput("rst_clk_n", {31'd0, a_clk_n}, 32'd1);
      checkOutput("rst_chan_p", {29'd0, a_chan_p}, 32'd0);
      checkOutput("rst_chan_n", {29'd0, a_chan_n}, 32'd7);
    end else if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1 at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      checkOutput("load", {31'd0, a_load}, {31'd0, e.load});
      checkOutput("clk_p", {31'd0, a_clk_p}, {31'd0, e.clk});
      checkOutput("chan_p", {29'd0, a_chan_p}, {29'd0, e.chan});
    end
  end

  initial begin
    logic [2:0][9:0] w;

    for (int i = 0; i < 5; i++) applyStimulus(1'b1);

    w[0] = 10'b1101010100; w[1] = 10'h3FF; w[2] = 10'h000;
    plan_q.push_back(w);
    w = 30'($urandom); w[0] = 10'h155;
    plan_q.push_back(w);
    w = 30'($urandom); w[0] = 10'h2AA;
    plan_q.push_back(w);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0);

    while (next_edge % 10 != 4) applyStimulus(1'b0);
    applyStimulus(1'b1);
    w[0] = 10'h2D3; w[1] = 10'h0F0; w[2] = 10'h381;
    plan_q.push_back(w);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0);

    for (int r = 0; r < 6; r++) begin
      int run_len = $urandom_range(5, 30);
      int rst_len = $urandom_range(1, 3);
      for (int i = 0; i < run_len; i++) applyStimulus(1'b0);
      for (int i = 0; i < rst_len; i++) applyStimulus(1'b1);
    end
    for (int i = 0; i < 30; i++) applyStimulus(1'b0);

    @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
